sqrt_job_controller: RTL and testbench

Upstream feeder and result conditioner for the Newton square-root core. Accepts 32-bit operands over a valid/ready stream and drives the core's START/in/DONE/AVAILABLE handshake. It then corrects the core's fixed-iteration estimate to the exact floor square root and presents root, remainder and error over a valid/ready result stream. It sits between the operand source (bus or test sequencer) and the core.

---
 rtl/sqrt_job_controller.sv | 165 ++++++++++++++++
 tb/tb_sqrt_job_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_job_controller.sv
// Operand feeder and result conditioner for the Newton square-root core: issues jobs,
// corrects the core's estimate to the exact floor root and returns root/remainder/error.
module sqrt_job_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_FIX_STEPS  = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [31:0] op_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_root,
  output logic [16:0] res_rem,
  output logic        res_err,
  output logic        sqrt_start,
  output logic [31:0] sqrt_in,
  input  logic [31:0] sqrt_out,
  input  logic        sqrt_done,
  input  logic        sqrt_available
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int FW = $clog2(MAX_FIX_STEPS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_DONE, S_RELEASE, S_FIX, S_DONE_OUT
  } state_e;

  state_e        state_q, state_d;
  logic          op_ready_q, op_ready_d;
  logic [31:0]   x_q, x_d;
  logic [15:0]   r_q, r_d;
  logic [15:0]   root_q, root_d;
  logic [16:0]   rem_q, rem_d;
  logic          err_q, err_d;
  logic          start_q, start_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [FW-1:0] fix_q, fix_d;

  // (r+1)^2 is derived from r^2 so a single 16x16 multiplier serves both compares.
  logic [31:0] sq_cur;
  logic [32:0] sq_nxt;
  assign sq_cur = {16'd0, r_q} * {16'd0, r_q};
  assign sq_nxt = {1'b0, sq_cur} + {16'd0, r_q, 1'b1};

  logic tmo_hit, fix_exhausted;
  assign tmo_hit       = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign fix_exhausted = (fix_q == FW'(MAX_FIX_STEPS));

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d = state_q;
    x_d     = x_q;
    r_d     = r_q;
    root_d  = root_q;
    rem_d   = rem_q;
    err_d   = err_q;
    start_d = start_q;
    tmo_d   = tmo_q;
    fix_d   = fix_q;

    unique case (state_q)
      S_IDLE: begin
        if (op_valid && op_ready_q) begin
          x_d     = op_data;
          root_d  = '0;
          rem_d   = '0;
          err_d   = 1'b0;
          fix_d   = '0;
          state_d = (op_data == 32'd0) ? S_DONE_OUT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (sqrt_available) begin
          start_d = 1'b1;
          tmo_d   = '0;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (sqrt_done) begin
          r_d     = (|sqrt_out[31:16]) ? 16'hFFFF : sqrt_out[15:0];
          start_d = 1'b0;
          tmo_d   = '0;
          state_d = S_RELEASE;
        end else if (tmo_hit) begin
          start_d = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE_OUT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_RELEASE: begin
        if (sqrt_available) begin
          state_d = S_FIX;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE_OUT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_FIX: begin
        if ((sq_cur > x_q) || (r_q != 16'hFFFF && sq_nxt <= {1'b0, x_q})) begin
          if (fix_exhausted) begin
            err_d   = 1'b1;
            state_d = S_DONE_OUT;
          end else begin
            r_d   = (sq_cur > x_q) ? r_q - 16'd1 : r_q + 16'd1;
            fix_d = fix_q + FW'(1);
          end
        end else begin
          root_d  = r_q;
          rem_d   = 17'(x_q - sq_cur);
          state_d = S_DONE_OUT;
        end
      end
      S_DONE_OUT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    op_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      op_ready_q <= 1'b0;
      x_q        <= '0;
      r_q        <= '0;
      root_q     <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      tmo_q      <= '0;
      fix_q      <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of the others.
      state_q    <= state_d;
      op_ready_q <= op_ready_d;
      x_q        <= x_d;
      r_q        <= r_d;
      root_q     <= root_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
      start_q    <= start_d;
      tmo_q      <= tmo_d;
      fix_q      <= fix_d;
    end
  end

  assign op_ready   = op_ready_q;
  assign res_valid  = (state_q == S_DONE_OUT);
  assign res_root   = root_q;
  assign res_rem    = rem_q;
  assign res_err    = err_q;
  assign sqrt_start = start_q;
  assign sqrt_in    = x_q;

endmodule

// File: tb/tb_sqrt_job_controller.sv
// Directed bench for sqrt_job_controller with a behavioural core stub and a result scoreboard.
module tb_sqrt_job_controller;

  logic        clk = 1'b0;
  logic        rstn;
  logic        op_valid, op_ready;
  logic [31:0] op_data;
  logic        res_valid, res_ready;
  logic [15:0] res_root;
  logic [16:0] res_rem;
  logic        res_err;
  logic        sqrt_start;
  logic [31:0] sqrt_in, sqrt_out;
  logic        sqrt_done, sqrt_available;

  sqrt_job_controller #(.TIMEOUT_CYCLES(64), .MAX_FIX_STEPS(4)) dut (
    .clk(clk), .rstn(rstn),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_root(res_root), .res_rem(res_rem), .res_err(res_err),
    .sqrt_start(sqrt_start), .sqrt_in(sqrt_in), .sqrt_out(sqrt_out),
    .sqrt_done(sqrt_done), .sqrt_available(sqrt_available)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] root;
    logic [16:0] rem;
    logic        err;
  } res_t;

  res_t sb[$];
  int   n_asserts = 0;
  int   n_fails   = 0;

  function automatic logic [15:0] isqrt(input logic [31:0] x);
    longint unsigned r = 0;
    longint unsigned t;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= {32'd0, x}) r = t;
    end
    return r[15:0];
  endfunction

  // Core stub: latency-limited, can hang, return an offset estimate or a forced 65537.
  logic        core_hang;
  int          core_offset;
  logic        core_force;
  int          core_lat = 5;
  int          cst, ccnt;
  logic [31:0] in_lat;
  int          in_changes   = 0;
  int          start_cycles = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cst            <= 0;
      ccnt           <= 0;
      sqrt_done      <= 1'b0;
      sqrt_available <= 1'b1;
      sqrt_out       <= '0;
      in_lat         <= '0;
    end else begin
      if (sqrt_start) start_cycles <= start_cycles + 1;
      case (cst)
        0: if (sqrt_start) begin
          cst <= 1; ccnt <= 0; in_lat <= sqrt_in; sqrt_available <= 1'b0;
        end
        1: begin
          if (sqrt_in !== in_lat) in_changes <= in_changes + 1;
          if (!sqrt_start) cst <= 2;
          else if (!core_hang && ccnt >= core_lat) begin
            sqrt_done <= 1'b1;
            sqrt_out  <= core_force ? 32'd65537 : 32'(int'(isqrt(sqrt_in)) + core_offset);
            cst       <= 3;
          end else ccnt <= ccnt + 1;
        end
        3: if (!sqrt_start) begin sqrt_done <= 1'b0; cst <= 2; end
        default: begin sqrt_available <= 1'b1; cst <= 0; end
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_op(input logic [31:0] x, input logic exp_err);
    int   cyc = 0;
    res_t e;
    while (!op_ready && cyc < 200) begin @(negedge clk); cyc++; end
    check("op_ready_wait", op_ready, 1);
    if (exp_err) begin
      e.root = '0; e.rem = '0; e.err = 1'b1;
    end else begin
      e.root = isqrt(x);
      e.rem  = 17'(x - {16'd0, e.root} * {16'd0, e.root});
      e.err  = 1'b0;
    end
    sb.push_back(e);
    op_valid = 1'b1;
    op_data  = x;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input int hold);
    int   cyc = 0;
    res_t e;
    while (!res_valid && cyc < 400) begin @(negedge clk); cyc++; end
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_root"}, res_root, e.root);
      check({tag, "_rem"}, res_rem, e.rem);
      check({tag, "_err"}, res_err, e.err);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, res_valid, 1);
        check({tag, "_hold_root"}, res_root, e.root);
        check({tag, "_hold_rem"}, res_rem, e.rem);
        check({tag, "_hold_opready"}, op_ready, 0);
      end
    end
    res_ready = 1'b1;
    check({tag, "_opready_before_hs"}, op_ready, 0);
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, res_valid, 0);
    check({tag, "_opready_after_hs"}, op_ready, 1);
  endtask

  initial begin
    int s0;
    int cyc;
    rstn = 1'b0; op_valid = 1'b0; op_data = '0; res_ready = 1'b0;
    core_hang = 1'b0; core_offset = 0; core_force = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_op_ready", op_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_root", res_root, 0);
    check("rst_rem", res_rem, 0);
    check("rst_err", res_err, 0);
    check("rst_start", sqrt_start, 0);
    check("rst_sqrt_in", sqrt_in, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_op_ready", op_ready, 1);

    // Zero operand bypasses the core and answers one cycle after accept.
    s0 = start_cycles;
    send_op(32'd0, 1'b0);
    check("zero_latency", res_valid, 1);
    get_result("zero", 0);
    check("zero_no_start", start_cycles - s0, 0);

    // Back-to-back small operands, with the core estimate off by +1 / -1.
    send_op(32'd16, 1'b0); get_result("x16", 0);
    core_offset = 1;
    send_op(32'd17, 1'b0); get_result("x17", 0);
    core_offset = -1;
    send_op(32'd15, 1'b0); get_result("x15", 0);
    core_offset = 0;

    // Upper boundary, then a core that overshoots past the 16-bit range.
    send_op(32'hFFFF_FFFF, 1'b0); get_result("xmax", 0);
    core_force = 1'b1;
    send_op(32'hFFFF_FFFF, 1'b0); get_result("xmax_clamp", 0);
    core_force = 1'b0;

    // Correction budget: four steps allowed, a fifth is an error.
    core_offset = 4;
    send_op(32'd1000, 1'b0); get_result("fix4", 0);
    core_offset = 5;
    send_op(32'd1000, 1'b1); get_result("fix5_err", 0);
    core_offset = 0;

    // Backpressure for ten cycles.
    send_op(32'd100, 1'b0); get_result("bp", 10);

    // Core never finishes: abort after the timeout window, then recover.
    core_hang = 1'b1;
    s0 = start_cycles;
    send_op(32'd50, 1'b1);
    get_result("hang", 0);
    check("hang_start_low", sqrt_start, 0);
    check("hang_start_cycles", start_cycles - s0, 64);
    core_hang = 1'b0;
    send_op(32'd9, 1'b0); get_result("after_hang", 0);

    // Reset while the core is busy.
    core_hang = 1'b1;
    send_op(32'd25, 1'b0);
    cyc = 0;
    while (!sqrt_start && cyc < 50) begin @(negedge clk); cyc++; end
    check("midrst_started", sqrt_start, 1);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midrst_start", sqrt_start, 0);
    check("midrst_valid", res_valid, 0);
    check("midrst_op_ready", op_ready, 0);
    check("midrst_root", res_root, 0);
    check("midrst_rem", res_rem, 0);
    check("midrst_err", res_err, 0);
    check("midrst_sqrt_in", sqrt_in, 0);
    sb.delete();
    core_hang = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("postrst_valid", res_valid, 0);
    send_op(32'd49, 1'b0); get_result("x49", 0);

    check("sqrt_in_stable", in_changes, 0);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
